// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl
// ---------------
// Sequences a multi-byte add or subtract through one external, combinational
// 8-bit adder-subtractor. Bytes go in LSB first, one per clock, and the carry
// is chained between them. The adder computes A + (B ^ {8{cin}}) + cin, so
// inversion and carry-in are coupled. The B byte is pre-conditioned here so
// that every byte computes A + (B ^ {8{op}}) + carry.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   start, op       request (sampled in IDLE only); 0 = A+B, 1 = A-B
//   opa, opb        operands, latched when start is accepted
//   busy, done      busy while bytes are processed; done is a one-cycle pulse
//   result          W-bit result, held until the next accepted start
//   carry_out       final carry (subtract: 1 = no borrow)
//   overflow        signed two's-complement overflow
//   add_a/b/cin     drive to the external 8-bit adder (0 when not running)
//   add_s, add_cout sum and carry back from the external adder
module addsub_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            idx;
  logic [NBYTES-1:0][7:0]   a_reg, b_reg, res_reg;
  logic                     op_reg;
  logic                     carry_reg;
  logic                     last_byte;

  assign last_byte = (idx == LAST);
  assign result    = res_reg;

  // Both status outputs decode registered state only, so they cannot glitch.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        add_a   = a_reg[idx];
        add_cin = carry_reg;
        // The adder inverts B whenever cin is set; pre-invert by (op ^ cin)
        // so the net operand is B ^ {8{op}} regardless of the chained carry.
        add_b   = b_reg[idx] ^ {8{op_reg ^ carry_reg}};
        if (last_byte) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      op_reg    <= 1'b0;
      carry_reg <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= opa;
            b_reg     <= opb;
            op_reg    <= op;
            // Subtract starts with carry 1: invert B and add one on byte 0.
            carry_reg <= op;
            idx       <= '0;
            res_reg   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        RUN: begin
          res_reg[idx] <= add_s;
          carry_reg    <= add_cout;
          idx          <= idx + IW'(1);
          if (last_byte) begin
            carry_out <= add_cout;
            // Same-sign effective operands producing a different-sign sum.
            overflow  <= (a_reg[NBYTES-1][7] == (b_reg[NBYTES-1][7] ^ op_reg))
                         && (add_s[7] != a_reg[NBYTES-1][7]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl. A combinational model of the
// external 8-bit adder is attached; expected results come from whole-word
// arithmetic on the operands.
module tb_addsub_seq_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int PERIOD = NBYTES + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] opa, opb;
  logic         busy, done;
  logic [W-1:0] result;
  logic         carry_out, overflow;
  logic [7:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // External adder: A + (B ^ {8{cin}}) + cin.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b ^ {8{add_cin}}}
                             + {8'd0, add_cin};

  addsub_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Whole-word reference: unsigned result/carry and signed range overflow.
  task automatic model(input bit m_op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r,
                       output bit c, output bit v);
    longint sa, sb, sr;
    longint smax, smin;
    logic [W:0] full;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (!m_op) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[W-1:0];
      c    = full[W];
      sr   = sa + sb;
    end else begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end
    v = (sr > smax) || (sr < smin);
  endtask

  // One full transaction from IDLE: latency, busy length, results, hold.
  task automatic do_op(input string tag, input bit m_op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    bit           ec, ev;
    int           lat, busy_cnt;
    model(m_op, a, b, er, ec, ev);
    @(negedge clk);
    start = 1'b1; op = m_op; opa = a; opb = b;
    @(posedge clk);
    #1;
    // Operands changing after acceptance must not matter.
    start = 1'b0; op = ~m_op; opa = $urandom; opb = $urandom;
    lat = 0; busy_cnt = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NBYTES + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(NBYTES));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_carry"}, 64'(carry_out), 64'(ec));
    check({tag, "_ovf"}, 64'(overflow), 64'(ev));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    check({tag, "_held"}, 64'({carry_out, overflow, result}),
          64'({ec, ev, er}));
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    bit           rop, ec, ev;
    logic [W-1:0] qa[$], qb[$];
    bit           qop[$];

    rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_outs", 64'({carry_out, overflow, result}), 64'(0));
    check("reset_adder", 64'({add_a, add_b, add_cin}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_op("add_ff_1",   1'b0, 32'h0000_00FF, 32'h0000_0001);
    do_op("sub_5_7",    1'b1, 32'h0000_0005, 32'h0000_0007);
    do_op("sub_7_5",    1'b1, 32'h0000_0007, 32'h0000_0005);
    do_op("add_max_1",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    do_op("add_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op("sub_min_1",  1'b1, 32'h8000_0000, 32'h0000_0001);
    do_op("sub_equal",  1'b1, 32'h1234_5678, 32'h1234_5678);
    check("idle_adder", 64'({add_a, add_b, add_cin}), 64'(0));

    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; rop = 1'($urandom);
      if (i % 4 == 1) rb = ~ra;
      do_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    // start held high with operands changing every cycle: only requests
    // sampled in IDLE are accepted, one every NBYTES+2 edges.
    @(negedge clk);
    for (int e = 0; e < 3 * PERIOD; e++) begin
      start = 1'b1; op = 1'($urandom); opa = $urandom; opb = $urandom;
      if (e % PERIOD == 0) begin
        qop.push_back(op); qa.push_back(opa); qb.push_back(opb);
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stream_busy_e%0d", e), 64'(busy),
            64'((e % PERIOD) < NBYTES));
      check($sformatf("stream_done_e%0d", e), 64'(done),
            64'((e % PERIOD) == NBYTES));
      if (done && qa.size() > 0) begin
        model(qop.pop_front(), qa.pop_front(), qb.pop_front(), er, ec, ev);
        check($sformatf("stream_res_e%0d", e),
              64'({carry_out, overflow, result}), 64'({ec, ev, er}));
      end
    end
    start = 1'b0;
    check("stream_all_done", 64'(qa.size()), 64'(0));

    // Reset in the middle of a run: immediate abort, no done afterwards.
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 32'h0102_0304; opb = 32'h1111_1111;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_outs", 64'({carry_out, overflow, result}), 64'(0));
    check("abort_adder", 64'({add_a, add_b, add_cin}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < NBYTES + 3; i++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort_no_done", 64'(seen), 64'(0));
    end
    do_op("after_abort", 1'b1, 32'h0000_0100, 32'h0000_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
Sequencer that performs multi-byte add/subtract by time-multiplexing the team's single 8-bit adder-subtractor, one byte per clock, LSB first. It chains the carry between bytes and conditions the B operand around the adder's coupled invert/carry-in control. It sits between a requesting unit (start/done handshake) and the 8-bit adder instance, which is external and combinational.

Parameters:
NBYTES, 4, operand width in bytes (>=2); operand width W = 8*NBYTES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = add (A+B), 1 = subtract (A-B); latched with start.
opa  input  W  operand A; latched with start.
opb  input  W  operand B; latched with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when result valid.
result  output  W  sum/difference; held until next accepted start.
carry_out  output  1  final byte carry (subtract: 1 = no borrow).
overflow  output  1  signed two's-complement overflow.
add_a  output  8  to adder A.
add_b  output  8  to adder B.
add_cin  output  1  to adder Cin (adder computes A + (B XOR {8{Cin}}) + Cin).
add_s  input  8  from adder sum.
add_cout  input  1  from adder carryout.

Behaviour:
- Reset (async, rst=1): state IDLE, idx=0, busy=0, done=0, result=0, carry_out=0, overflow=0, operand/op/carry registers 0.
- States: IDLE, RUN, DONE.
- IDLE: adder outputs driven 0. start=1 at edge -> latch opa, opb, op; carry reg <= op; idx <= 0; result <= 0; carry_out, overflow <= 0; -> RUN.
- RUN: combinational drive: add_a = A byte[idx]; add_cin = carry reg; add_b = B byte[idx] XOR {8{op XOR add_cin}} (net effect per byte: A + (B XOR {8{op}}) + carry). Each edge: result byte[idx] <= add_s; carry reg <= add_cout; idx++. On idx = NBYTES-1: carry_out <= add_cout; overflow <= (a7 == e7) AND (s7 != a7), where a7 = A bit W-1, e7 = B bit W-1 XOR op, s7 = add_s[7]; -> DONE.
- DONE: done=1 for exactly one cycle, adder outputs 0; -> IDLE unconditionally.
- busy = (state == RUN); done = (state == DONE); both registered-state decodes, glitch-free.
- Latency: start sampled at edge k -> RUN edges k+1..k+NBYTES -> done high in cycle after edge k+NBYTES (NBYTES+1 cycles). Throughput one op per NBYTES+2 cycles.
- start while RUN or DONE: ignored, no queueing; operands/op changes after acceptance have no effect.
- Byte 0 subtract: carry reg = 1, so adder inverts B and adds 1 (two's complement); later bytes re-derive inversion from op XOR carry.
- Wrap-around: result is modulo 2^W; carry beyond bit W-1 only reported on carry_out.
- Reset asserted mid-RUN: immediate abort to IDLE, all outputs to reset values, no done pulse.
- result/carry_out/overflow stable from DONE until next accepted start.

Test Plan:
- Reset then add 0x000000FF + 0x00000001 -> busy 4 cycles, done pulse at cycle 5, result 0x00000100, carry_out 0, overflow 0.
- Subtract 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry_out 0, overflow 0; subtract 7 - 5 -> result 0x00000002, carry_out 1.
- Add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, carry_out 0; add 0xFFFFFFFF + 0x00000001 -> result 0, carry_out 1, overflow 0.
- Subtract 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1, carry_out 1.
- Start held high continuously with changing operands -> only IDLE-sampled requests accepted, one done per NBYTES+2 cycles, results match operands at acceptance.
- rst pulsed during RUN (after byte 1) -> outputs zero immediately, no done; next start completes correctly.
